// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: S-box depth, key-schedule FSM states and key byte extraction.
package arc4_pkg;

  localparam int S_DEPTH   = 256;
  localparam int KEY_MAX   = 32;
  localparam int KEY_EXT_W = 8 * KEY_MAX;

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    RD_I,
    WAIT_I,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J,
    DONE
  } state_t;

  // Big-endian: byte 0 lives in the top 8 bits of an nbytes-wide key.
  function automatic logic [7:0] key_byte(input logic [KEY_EXT_W-1:0] key,
                                          input int nbytes, input int idx);
    return key[8*(nbytes-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/ksa_gen_if.sv
// Controller handshake and S-RAM port of the key-scheduling engine.
interface ksa_gen_if #(parameter int KEY_BYTES = 3);

  logic                   en;
  logic                   rdy;
  logic                   init;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  modport master (
    input  en, init, key, rddata,
    output rdy, addr, wrdata, wren
  );

  modport slave (
    output en, init, key, rddata,
    input  rdy, addr, wrdata, wren
  );

endinterface

// File: rtl/ksa_gen.sv
// ARC4 key-scheduling engine driving an external single-port S-RAM, with
// optional identity fill, configurable key length and RAM read latency.
module ksa_gen
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  ksa_gen_if.master  bus
);

  localparam int KW     = 8 * KEY_BYTES;
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  state_t              state;
  logic [7:0]          i, j, si;
  logic [KIDX_W-1:0]   kidx;
  logic                wcnt;
  logic [KW-1:0]       key_q;
  logic [7:0]          addr_q, wrdata_q;
  logic                wren_q, rdy_q;

  logic [KEY_EXT_W-1:0] key_ext;
  logic [7:0]           kb, j_nxt;
  logic                 wait_last;

  assign key_ext   = KEY_EXT_W'(key_q);
  assign kb        = key_byte(key_ext, KEY_BYTES, int'(kidx));
  assign j_nxt     = j + bus.rddata + kb;
  assign wait_last = (wcnt == 1'(RD_LAT - 1));

  assign bus.rdy    = rdy_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.wren   = wren_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      kidx     <= '0;
      wcnt     <= '0;
      key_q    <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en && rdy_q) begin
            key_q    <= bus.key;
            i        <= '0;
            j        <= '0;
            kidx     <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            rdy_q    <= 1'b0;
            if (bus.init) begin
              state  <= FILL;
              wren_q <= 1'b1;
            end else begin
              state  <= RD_I;
            end
          end
        end

        FILL: begin
          if (addr_q == 8'(S_DEPTH - 1)) begin
            state  <= RD_I;
            addr_q <= i;
            wren_q <= 1'b0;
          end else begin
            addr_q   <= addr_q + 8'd1;
            wrdata_q <= wrdata_q + 8'd1;
          end
        end

        RD_I: begin
          state <= WAIT_I;
          wcnt  <= '0;
        end

        // addr holds through the wait, so rddata is S[i] on the last cycle.
        WAIT_I: begin
          if (wait_last) begin
            si     <= bus.rddata;
            j      <= j_nxt;
            addr_q <= j_nxt;
            state  <= RD_J;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        RD_J: begin
          state <= WAIT_J;
          wcnt  <= '0;
        end

        // The write-data register doubles as the sj holding register.
        WAIT_J: begin
          if (wait_last) begin
            wrdata_q <= bus.rddata;
            addr_q   <= i;
            wren_q   <= 1'b1;
            state    <= WR_I;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        WR_I: begin
          addr_q   <= j;
          wrdata_q <= si;
          state    <= WR_J;
        end

        WR_J: begin
          wren_q <= 1'b0;
          if (i == 8'(S_DEPTH - 1)) begin
            state <= DONE;
          end else begin
            i      <= i + 8'd1;
            addr_q <= i + 8'd1;
            kidx   <= (kidx == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
            state  <= RD_I;
          end
        end

        DONE: begin
          rdy_q <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_rdy_idle: assert property (@(posedge clk) disable iff (!rst_n)
    rdy_q == (state == IDLE));

  a_wren_state: assert property (@(posedge clk) disable iff (!rst_n)
    wren_q == (state inside {FILL, WR_I, WR_J}));

endmodule

// File: tb/tb_ksa_gen.sv
// Directed bench for ksa_gen: three configurations, each with its own S-RAM
// model, compared against an RC4 key schedule computed in the bench.
module tb_ksa_gen;

  logic         clk;
  logic         rst_n;
  logic [2:0]   en_v;
  logic         init_v;
  logic [255:0] key_v;
  logic         preload_b;

  int passed;
  int total;

  logic [7:0] gold [256];
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [256];
  logic [7:0] rd_a, rd_b1, rd_b2, rd_c;

  ksa_gen_if #(.KEY_BYTES(3))  if_a ();
  ksa_gen_if #(.KEY_BYTES(16)) if_b ();
  ksa_gen_if #(.KEY_BYTES(1))  if_c ();

  ksa_gen #(.KEY_BYTES(3),  .RD_LAT(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  ksa_gen #(.KEY_BYTES(16), .RD_LAT(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  ksa_gen #(.KEY_BYTES(1),  .RD_LAT(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  assign if_a.en = en_v[0];
  assign if_b.en = en_v[1];
  assign if_c.en = en_v[2];
  assign if_a.init = init_v;
  assign if_b.init = init_v;
  assign if_c.init = init_v;
  assign if_a.key = key_v[23:0];
  assign if_b.key = key_v[127:0];
  assign if_c.key = key_v[7:0];
  assign if_a.rddata = rd_a;
  assign if_b.rddata = rd_b2;
  assign if_c.rddata = rd_c;

  logic [7:0] addr_v [3];
  logic [7:0] wrd_v  [3];
  logic       wren_v [3];
  logic       rdy_v  [3];
  assign addr_v[0] = if_a.addr;   assign addr_v[1] = if_b.addr;   assign addr_v[2] = if_c.addr;
  assign wrd_v[0]  = if_a.wrdata; assign wrd_v[1]  = if_b.wrdata; assign wrd_v[2]  = if_c.wrdata;
  assign wren_v[0] = if_a.wren;   assign wren_v[1] = if_b.wren;   assign wren_v[2] = if_c.wren;
  assign rdy_v[0]  = if_a.rdy;    assign rdy_v[1]  = if_b.rdy;    assign rdy_v[2]  = if_c.rdy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM models (latency 1, 2, 1).
  always @(posedge clk) begin
    if (if_a.wren) mem_a[if_a.addr] <= if_a.wrdata;
    rd_a <= mem_a[if_a.addr];
  end

  always @(posedge clk) begin
    if (preload_b) begin
      for (int x = 0; x < 256; x++) mem_b[x] <= x[7:0];
    end else if (if_b.wren) begin
      mem_b[if_b.addr] <= if_b.wrdata;
    end
    rd_b1 <= mem_b[if_b.addr];
    rd_b2 <= rd_b1;
  end

  always @(posedge clk) begin
    if (if_c.wren) mem_c[if_c.addr] <= if_c.wrdata;
    rd_c <= mem_c[if_c.addr];
  end

  typedef struct {
    string        name;
    int           sel;
    logic [255:0] key;
    int           nb;
    bit           ini;
    bit           pre;
    int           exp_cyc;
    int           exp_wr;
    logic [7:0]   a0, d0, a1, d1;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  // Textbook RC4 KSA from the identity permutation.
  task automatic gold_ksa(input logic [255:0] k, input int nb);
    logic [7:0] jj, t;
    for (int x = 0; x < 256; x++) gold[x] = x[7:0];
    jj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + gold[x] + k[8*(nb-1-(x % nb)) +: 8];
      t = gold[x]; gold[x] = gold[jj]; gold[jj] = t;
    end
  endtask

  function automatic int mism(input int sel);
    int n = 0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      case (sel)
        0:       v = mem_a[x];
        1:       v = mem_b[x];
        default: v = mem_c[x];
      endcase
      if (v !== gold[x]) n++;
    end
    return n;
  endfunction

  task automatic start(input int sel, input logic [255:0] k, input bit ini, input bit hold);
    key_v = k;
    init_v = ini;
    en_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) en_v[sel] = 1'b0;
  endtask

  // Counts cycles from the accept edge until rdy, and records the first
  // post-fill write pair.
  task automatic wait_done(input int sel, input int cap, output int cyc, output int nwr,
                           output logic [7:0] a0, output logic [7:0] d0,
                           output logic [7:0] a1, output logic [7:0] d1,
                           input bit swap_key, input logic [255:0] k2);
    cyc = 0; nwr = 0;
    a0 = 'x; d0 = 'x; a1 = 'x; d1 = 'x;
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (swap_key && cyc == 100) key_v = k2;
      if (wren_v[sel]) begin
        nwr++;
        if (nwr == cap + 1) begin a0 = addr_v[sel]; d0 = wrd_v[sel]; end
        if (nwr == cap + 2) begin a1 = addr_v[sel]; d1 = wrd_v[sel]; end
      end
      if (rdy_v[sel]) break;
    end
    if (cyc >= 5000) chk("timeout", cyc, 0);
  endtask

  task automatic set_vec(input int n, input string name, input int sel, input logic [255:0] k,
                         input int nb, input bit ini, input bit pre, input int ec, input int ew,
                         input logic [7:0] a0, input logic [7:0] d0,
                         input logic [7:0] a1, input logic [7:0] d1);
    vt[n].name = name; vt[n].sel = sel; vt[n].key = k; vt[n].nb = nb;
    vt[n].ini = ini; vt[n].pre = pre; vt[n].exp_cyc = ec; vt[n].exp_wr = ew;
    vt[n].a0 = a0; vt[n].d0 = d0; vt[n].a1 = a1; vt[n].d1 = d1;
  endtask

  initial begin
    int cyc, nwr;
    logic [7:0] a0, d0, a1, d1;
    logic [255:0] ka, kb2;

    passed = 0; total = 0;
    en_v = '0; init_v = 1'b0; key_v = '0; preload_b = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_rdy",    int'(if_a.rdy), 1);
    chk("reset_wren",   int'(if_a.wren), 0);
    chk("reset_addr",   int'(if_a.addr), 0);
    chk("reset_wrdata", int'(if_a.wrdata), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_vec(0, "k3_key02",  0, 256'h000002, 3,  1'b1, 1'b0, 1794, 768, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(1, "k3_zero",   0, 256'h000000, 3,  1'b1, 1'b0, 1794, 768, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(2, "k16_lat2",  1, 256'h0102030405060708090a0b0c0d0e0f10, 16, 1'b0, 1'b1,
            2050, 512, 8'h00, 8'h01, 8'h01, 8'h00);
    set_vec(3, "k1_ff",     2, 256'hFF, 1, 1'b1, 1'b0, 1794, 768, 8'h00, 8'hFF, 8'hFF, 8'h00);

    for (int v = 0; v < 4; v++) begin
      if (vt[v].pre) begin
        @(negedge clk) preload_b = 1'b1;
        @(negedge clk) preload_b = 1'b0;
      end
      gold_ksa(vt[v].key, vt[v].nb);
      start(vt[v].sel, vt[v].key, vt[v].ini, 1'b0);
      wait_done(vt[v].sel, vt[v].ini ? 256 : 0, cyc, nwr, a0, d0, a1, d1, 1'b0, '0);
      chk({vt[v].name, "_cycles"}, cyc, vt[v].exp_cyc);
      chk({vt[v].name, "_writes"}, nwr, vt[v].exp_wr);
      chk({vt[v].name, "_wr0"}, int'({a0, d0}), int'({vt[v].a0, vt[v].d0}));
      chk({vt[v].name, "_wr1"}, int'({a1, d1}), int'({vt[v].a1, vt[v].d1}));
      chk({vt[v].name, "_sbox_mismatches"}, mism(vt[v].sel), 0);
    end

    // Reset in the middle of a run.
    start(0, 256'h0a0b0c, 1'b1, 1'b0);
    repeat (600) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", int'(if_a.wren), 0);
    chk("midrst_rdy",  int'(if_a.rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    nwr = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_a.wren) nwr++;
    end
    chk("midrst_quiet", nwr, 0);
    gold_ksa(256'h000002, 3);
    start(0, 256'h000002, 1'b1, 1'b0);
    wait_done(0, 256, cyc, nwr, a0, d0, a1, d1, 1'b0, '0);
    chk("after_rst_cycles", cyc, 1794);
    chk("after_rst_sbox_mismatches", mism(0), 0);

    // en held high; key changed mid-run must not matter until restart.
    ka = 256'h123456;
    kb2 = 256'hc0ffee;
    start(0, ka, 1'b1, 1'b1);
    wait_done(0, 256, cyc, nwr, a0, d0, a1, d1, 1'b1, kb2);
    chk("hold_cycles", cyc, 1794);
    chk("hold_writes", nwr, 768);
    gold_ksa(ka, 3);
    chk("hold_latched_key_sbox_mismatches", mism(0), 0);
    @(posedge clk);
    #1 en_v[0] = 1'b0;
    wait_done(0, 256, cyc, nwr, a0, d0, a1, d1, 1'b0, '0);
    chk("restart_cycles", cyc, 1794);
    gold_ksa(kb2, 3);
    chk("restart_sbox_mismatches", mism(0), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
